divide_bits: RTL

DIVIDE_BITS -- requirements
Module: divide_bits

---
 rtl/divide_bits_pkg.sv | 21 ++
 rtl/div_step.sv | 34 +++
 rtl/divide_bits.sv | 123 ++++++++++++
 3 files changed

// File: rtl/divide_bits_pkg.sv
// Shared definitions for the signed restoring divider: FSM encoding,
// default operand width and iteration-counter sizing.
package divide_bits_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Counter must hold the value WIDTH, hence one bit beyond clog2.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  localparam int unsigned CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/div_step.sv
// One unsigned restoring shift-subtract iteration built on a ripple
// borrow chain; the trial difference is kept only when it does not borrow.
module div_step
  import divide_bits_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   borrow;
  logic             borrow_out;

  always_comb begin
    part   = {rem_i, bit_i};
    diff   = '0;
    borrow = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      diff[i]       = part[i] ^ dvs_i[i] ^ borrow[i];
      borrow[i+1]   = (~part[i] & dvs_i[i]) | (~part[i] & borrow[i]) | (dvs_i[i] & borrow[i]);
    end
    // The divisor is zero-extended, so the top stage only propagates the borrow.
    borrow_out = ~part[WIDTH] & borrow[WIDTH];
    q_o        = ~borrow_out;
    rem_o      = q_o ? diff : part[WIDTH-1:0];
  end

endmodule

// File: rtl/divide_bits.sv
// Multi-cycle signed divider: magnitudes are divided over WIDTH CALC cycles,
// signs are applied in FIX, and results hold until the next completion.
module divide_bits
  import divide_bits_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] HI,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvs_i (dvs_q),
    .bit_i (quo_q[WIDTH-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dbz_d   = dbz_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d  = RA[WIDTH-1];
          sb_d  = RB[WIDTH-1];
          quo_d = RA[WIDTH-1] ? -RA : RA;
          dvs_d = RB[WIDTH-1] ? -RB : RB;
          rem_d = '0;
          cnt_d = '0;
          dbz_d = (RB == '0);
          if (RB == '0) begin
            lo_d    = '1;
            hi_d    = RA;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // quo_q shifts out dividend bits at the top and takes quotient bits in at the bottom.
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        lo_d    = (sa_q ^ sb_q) ? -quo_q : quo_q;
        hi_d    = sa_q ? -rem_q : rem_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dbz_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dbz_q   <= dbz_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign div_by_zero = done & dbz_q;
  assign LO          = lo_q;
  assign HI          = hi_q;

endmodule
